dsp_slice_param: RTL

DSP_SLICE_PARAM -- requirements
Module: dsp_slice_param

---
 rtl/dsp_slice_pkg.sv | 53 +++++
 rtl/dsp_coef_bank.sv | 30 +++
 rtl/dsp_slice_param.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/dsp_slice_pkg.sv
// Shared types, default widths and accumulator range helpers for the DSP slice.
package dsp_slice_pkg;

    typedef enum logic {
        MODE_SUM   = 1'b0,  // p0 +/- p1 into the accumulator
        MODE_INDEP = 1'b1   // p0 accumulates, p1 goes out on resultb
    } dsp_mode_e;

    localparam int DEF_A_W          = 18;
    localparam int DEF_B_W          = 19;
    localparam int DEF_ACC_W        = 64;
    localparam int DEF_COEF_DEPTH   = 8;
    localparam int DEF_CONST_SHIFT  = 8;

    // Widest accumulator the helpers below can range-check.
    localparam int SAT_MAX_W        = 128;
    localparam int SAT_X_W          = SAT_MAX_W + 2;

    // Per-beat controls that ride alongside the operands.
    typedef struct packed {
        dsp_mode_e mode;
        logic      sub;
        logic      negate;
        logic      accumulate;
        logic      loadconst;
        logic      chain_en;
    } dsp_ctrl_t;

    // Largest positive value of a w-bit signed number.
    function automatic logic signed [SAT_X_W-1:0] acc_max(input int unsigned w);
        return (SAT_X_W'(1) << (w - 1)) - SAT_X_W'(1);
    endfunction

    // True when x does not fit a w-bit signed number.
    function automatic logic acc_ovf(input logic signed [SAT_X_W-1:0] x,
                                     input int unsigned w);
        logic signed [SAT_X_W-1:0] hi;
        hi = acc_max(w);
        return (x > hi) || (x < ~hi);
    endfunction

    // Clamp to the w-bit signed range when sat is set, otherwise keep low bits.
    function automatic logic [SAT_MAX_W-1:0] sat_clamp(input logic signed [SAT_X_W-1:0] x,
                                                       input int unsigned w,
                                                       input logic sat);
        logic signed [SAT_X_W-1:0] hi;
        hi = acc_max(w);
        if (sat && (x > hi)) return SAT_MAX_W'(hi);
        if (sat && (x < ~hi)) return SAT_MAX_W'(~hi);
        return SAT_MAX_W'(x);
    endfunction

endpackage

// File: rtl/dsp_coef_bank.sv
// Coefficient register file: one write port, two asynchronous read ports.
// A read in the same cycle as a write to that entry returns the old contents.
module dsp_coef_bank #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 19
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] rd_addr_a_i,
    output logic [DW-1:0] rd_data_a_o,
    input  logic [AW-1:0] rd_addr_b_i,
    output logic [DW-1:0] rd_data_b_o
);

    logic [DEPTH-1:0][DW-1:0] mem_q;

    // Reset wipes every entry and masks any write issued during reset.
    always_ff @(posedge clk_i) begin
        if (reset_i)      mem_q <= '0;
        else if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    assign rd_data_a_o = mem_q[rd_addr_a_i];
    assign rd_data_b_o = mem_q[rd_addr_b_i];

endmodule

// File: rtl/dsp_slice_param.sv
// Three-stage dual-multiplier DSP slice: capture, multiply, accumulate.
// Accumulator range checking relies on ACC_W <= 128 and ACC_W >= A_W+B_W+1.
module dsp_slice_param
    import dsp_slice_pkg::*;
#(
    parameter int A_W         = DEF_A_W,
    parameter int B_W         = DEF_B_W,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int COEF_DEPTH  = DEF_COEF_DEPTH,
    parameter int CONST_SHIFT = DEF_CONST_SHIFT,
    parameter int SATURATE    = 0,
    localparam int CA_W       = $clog2(COEF_DEPTH),
    localparam int P_W        = A_W + B_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             in_valid_i,
    input  logic             mode_i,
    input  logic [A_W-1:0]   a0_i,
    input  logic [A_W-1:0]   a1_i,
    input  logic [B_W-1:0]   b0_i,
    input  logic [B_W-1:0]   b1_i,
    input  logic             coef_sel_a_i,
    input  logic             coef_sel_b_i,
    input  logic [CA_W-1:0]  coef_addr_a_i,
    input  logic [CA_W-1:0]  coef_addr_b_i,
    input  logic             coef_wr_en_i,
    input  logic [CA_W-1:0]  coef_wr_addr_i,
    input  logic [B_W-1:0]   coef_wr_data_i,
    input  logic             sub_i,
    input  logic             negate_i,
    input  logic             accumulate_i,
    input  logic             loadconst_i,
    input  logic             chain_en_i,
    input  logic [ACC_W-1:0] chainin_i,
    output logic [ACC_W-1:0] resulta_o,
    output logic [P_W-1:0]   resultb_o,
    output logic [ACC_W-1:0] chainout_o,
    output logic             out_valid_o,
    output logic             overflow_o
);

    // Two guard bits so the three-way sum never wraps before range checking.
    localparam int X_W = ACC_W + 2;
    localparam logic signed [X_W-1:0] CONST_X = X_W'(1) << CONST_SHIFT;

    logic [3:1]              vld_q;
    dsp_ctrl_t               ctrl1_q, ctrl2_q;
    logic signed [A_W-1:0]   a0_q, a1_q;
    logic signed [B_W-1:0]   b0_q, b1_q;
    logic signed [P_W-1:0]   p0_q, p1_q;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [P_W-1:0]          resb_q;
    logic                    ovf_q, ovf_d;
    logic [B_W-1:0]          coef_a, coef_b;
    logic signed [X_W-1:0]   sum_x, term_x, fb_x, chain_x, acc_next;

    dsp_coef_bank #(
        .DEPTH (COEF_DEPTH),
        .AW    (CA_W),
        .DW    (B_W)
    ) u_coef_bank (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .wr_en_i     (coef_wr_en_i),
        .wr_addr_i   (coef_wr_addr_i),
        .wr_data_i   (coef_wr_data_i),
        .rd_addr_a_i (coef_addr_a_i),
        .rd_data_a_o (coef_a),
        .rd_addr_b_i (coef_addr_b_i),
        .rd_data_b_o (coef_b)
    );

    // Beat valid shift register; reset drops every in-flight beat.
    always_ff @(posedge clk_i) begin
        if (reset_i)       vld_q <= '0;
        else if (enable_i) vld_q <= {vld_q[2:1], in_valid_i};
    end

    // S1: capture operands and controls, substituting bank coefficients.
    always_ff @(posedge clk_i) begin
        if (enable_i) begin
            ctrl1_q <= '{mode: dsp_mode_e'(mode_i), sub: sub_i, negate: negate_i,
                         accumulate: accumulate_i, loadconst: loadconst_i,
                         chain_en: chain_en_i};
            a0_q    <= a0_i;
            a1_q    <= a1_i;
            b0_q    <= coef_sel_a_i ? coef_a : b0_i;
            b1_q    <= coef_sel_b_i ? coef_b : b1_i;
        end
    end

    // S2: both signed products.
    always_ff @(posedge clk_i) begin
        if (enable_i) begin
            ctrl2_q <= ctrl1_q;
            p0_q    <= P_W'(a0_q) * P_W'(b0_q);
            p1_q    <= P_W'(a1_q) * P_W'(b1_q);
        end
    end

    // S3 next-state: combine products, feedback and chain, then range check.
    always_comb begin
        sum_x = X_W'(p0_q);
        if (ctrl2_q.mode == MODE_SUM)
            sum_x = ctrl2_q.sub ? X_W'(p0_q) - X_W'(p1_q) : X_W'(p0_q) + X_W'(p1_q);
        term_x = ctrl2_q.negate ? -sum_x : sum_x;
        fb_x = '0;
        if (ctrl2_q.accumulate) fb_x = X_W'(acc_q);
        if (ctrl2_q.loadconst)  fb_x = fb_x + CONST_X;
        chain_x  = ctrl2_q.chain_en ? X_W'($signed(chainin_i)) : '0;
        acc_next = fb_x + term_x + chain_x;
        ovf_d    = acc_ovf(SAT_X_W'(acc_next), ACC_W);
        acc_d    = ACC_W'(sat_clamp(SAT_X_W'(acc_next), ACC_W, SATURATE != 0));
    end

    // S3: results update only for valid beats; overflow flags that beat alone.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q  <= '0;
            resb_q <= '0;
            ovf_q  <= 1'b0;
        end else if (enable_i) begin
            if (vld_q[2]) begin
                acc_q  <= acc_d;
                resb_q <= (ctrl2_q.mode == MODE_INDEP) ? p1_q : '0;
                ovf_q  <= ovf_d;
            end else begin
                ovf_q  <= 1'b0;
            end
        end
    end

    assign resulta_o   = acc_q;
    assign chainout_o  = acc_q;
    assign resultb_o   = resb_q;
    assign out_valid_o = vld_q[3];
    assign overflow_o  = ovf_q;

endmodule
